// File: rtl/comparator_seq_ctrl.sv
// comparator_seq_ctrl: compares two WIDTH-bit unsigned operands MSB-first,
// one 2-bit digit per clock, through a shared external 2-bit comparator slice.
// The first unequal digit ends the comparison early.

module comparator_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_e,
  input  logic             slice_g,
  input  logic             slice_l,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             g,
  output logic             l,
  output logic             err
);

  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic             one_hot;

  // Slice flags are trusted only when exactly one of them is set.
  assign one_hot = ({slice_e, slice_g, slice_l} == 3'b100) ||
                   ({slice_e, slice_g, slice_l} == 3'b010) ||
                   ({slice_e, slice_g, slice_l} == 3'b001);

  // Digit select: mux the captured operands at the current index (register-fed only).
  always_comb begin
    slice_a = 2'b00;
    slice_b = 2'b00;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        slice_a = a_reg[2*i +: 2];
        slice_b = b_reg[2*i +: 2];
      end
    end
  end

  // Sequencer: operand capture, digit walk, result flags and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      e     <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
      err   <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= IW'(N - 1);
            e     <= 1'b0;
            g     <= 1'b0;
            l     <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!one_hot) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else if (slice_g) begin
            g     <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else if (slice_l) begin
            l     <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else if (idx == '0) begin
            e     <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx   <= idx - IW'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
// Self-checking bench for comparator_seq_ctrl: directed cases plus randomized
// operands against a plain-arithmetic reference model.

module tb_comparator_seq_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   slice_a;
  logic [1:0]   slice_b;
  logic         slice_e;
  logic         slice_g;
  logic         slice_l;
  logic         busy;
  logic         done;
  logic         e;
  logic         g;
  logic         l;
  logic         err;

  // 0: behavioural comparator, 1: force e and g, 2: force no flags
  logic [1:0]   ovr = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign slice_e = (ovr == 2'd0) ? (slice_a == slice_b) : (ovr == 2'd1);
  assign slice_g = (ovr == 2'd0) ? (slice_a >  slice_b) : (ovr == 2'd1);
  assign slice_l = (ovr == 2'd0) ? (slice_a <  slice_b) : 1'b0;

  comparator_seq_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .slice_a (slice_a),
    .slice_b (slice_b),
    .slice_e (slice_e),
    .slice_g (slice_g),
    .slice_l (slice_l),
    .busy    (busy),
    .done    (done),
    .e       (e),
    .g       (g),
    .l       (l),
    .err     (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] digit(input logic [W-1:0] v, input int i);
    logic [W-1:0] s;
    s = v >> (2 * i);
    return s[1:0];
  endfunction

  // One comparison: model expectation, drive, walk digits, check latency and flags.
  // junk=1 keeps start high with altered operands while busy (must be ignored).
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [1:0] mode, input bit junk);
    int   k;
    int   cyc;
    int   guard;
    logic xe, xg, xl, xerr;

    k = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (digit(ta, i) != digit(tb_v, i)) begin
        k = N - i;
        break;
      end
    end
    xe = (ta == tb_v); xg = (ta > tb_v); xl = (ta < tb_v); xerr = 1'b0;
    if (mode != 2'd0) begin
      k = 1; xe = 1'b0; xg = 1'b0; xl = 1'b0; xerr = 1'b1;
    end

    guard = 0;
    while (busy && guard < int'(N) + 4) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_before_start", busy, 1'b0);

    ovr   = mode;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    if (!junk) start = 1'b0;

    cyc = 0;
    while (!done && cyc < int'(N) + 4) begin
      check("busy_in_run", busy, 1'b1);
      if (cyc < int'(N)) begin
        check("slice_a", slice_a, digit(ta, N - 1 - cyc));
        check("slice_b", slice_b, digit(tb_v, N - 1 - cyc));
      end
      if (junk) begin
        start = 1'b1;
        a = ~ta;
        b = ~tb_v;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, k);
    check("busy_at_done", busy, 1'b1);
    check("flag_e", e, xe);
    check("flag_g", g, xg);
    check("flag_l", l, xl);
    check("flag_err", err, xerr);
    ovr = 2'd0;

    if (!junk) begin
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("busy_after_fin", busy, 1'b0);
      check("flags_hold", {e, g, l, err}, {xe, xg, xl, xerr});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int           sel;
    int           pos;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, e, g, l, err}, 6'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmp(8'hA5, 8'hA5, 2'd0, 1'b0);   // equal: all digits examined
    run_cmp(8'h80, 8'h7F, 2'd0, 1'b0);   // MSB digit decides
    run_cmp(8'h34, 8'h36, 2'd0, 1'b0);   // LSB digit decides

    run_cmp(8'h00, 8'hFF, 2'd0, 1'b1);   // start held with new operands while busy
    run_cmp(8'hFF, 8'h00, 2'd0, 1'b0);   // accepted in the cycle after FIN

    // Reset during the second RUN cycle aborts without a done pulse.
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", {busy, done, e, g, l, err}, 6'b0);
    repeat (6) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 1'b0);
    end
    run_cmp(8'h12, 8'h13, 2'd0, 1'b0);

    run_cmp(8'h5A, 8'h5A, 2'd1, 1'b0);   // e and g both set
    run_cmp(8'h5A, 8'h5A, 2'd2, 1'b0);   // no flag set

    for (int it = 0; it < 40; it++) begin
      ra  = W'($urandom);
      sel = int'($urandom_range(0, 2));
      if (sel == 0) begin
        rb = W'($urandom);
      end else if (sel == 1) begin
        rb = ra;
      end else begin
        pos = int'($urandom_range(0, N - 1));
        rb  = ra ^ (W'($urandom_range(1, 3)) << (2 * pos));
      end
      run_cmp(ra, rb, 2'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
